// File: rtl/brisc_pkg.sv
// Shared memory-interface types for the brisc cache/memory subsystem,
// plus the arbiter's requester-id and state encodings.
package brisc_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 128;

  typedef struct packed {
    logic                  valid;
    logic                  rw;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic                  ready;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } mem_resp_t;

  typedef enum logic {REQ_ICACHE = 1'b0, REQ_DCACHE = 1'b1} mem_req_id_e;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} mem_arb_state_e;

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner selection: a lone requester always wins; on contention
// either alternate against the last grant or let the D-cache win.
module arb_pick2
  import brisc_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        valid_i,
  input  logic        valid_d,
  input  mem_req_id_e last_grant,
  output logic        any,
  output mem_req_id_e winner
);

  always_comb begin
    any    = valid_i | valid_d;
    winner = REQ_DCACHE;
    if (valid_i && !valid_d) begin
      winner = REQ_ICACHE;
    end else if (valid_i && valid_d && ROUND_ROBIN && (last_grant == REQ_DCACHE)) begin
      winner = REQ_ICACHE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between I-cache and D-cache; one
// transaction at a time, response routed only to the granted requester.
module mem_arbiter
  import brisc_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  mem_req_t  icache_req_i,
  input  mem_req_t  dcache_req_i,
  output mem_resp_t icache_resp_o,
  output mem_resp_t dcache_resp_o,
  output mem_req_t  mem_req_o,
  input  mem_resp_t mem_resp_i
);

  mem_arb_state_e state_q;
  mem_req_id_e    grant_q;
  mem_req_id_e    last_grant_q;
  mem_req_t       req_q;
  mem_req_t       req_d;

  logic           pick_any;
  mem_req_id_e    pick_winner;

  arb_pick2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .valid_i    (icache_req_i.valid),
    .valid_d    (dcache_req_i.valid),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  always_comb begin
    req_d = (pick_winner == REQ_DCACHE) ? dcache_req_i : icache_req_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= REQ_ICACHE;
      last_grant_q <= REQ_ICACHE;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            state_q      <= ARB_BUSY;
            grant_q      <= pick_winner;
            last_grant_q <= pick_winner;
          end
        end
        ARB_BUSY: begin
          if (mem_resp_i.ready) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Request payload is only meaningful while BUSY, so it carries no reset.
  always_ff @(posedge clk) begin
    if ((state_q == ARB_IDLE) && pick_any) begin
      req_q <= req_d;
    end
  end

  always_comb begin
    mem_req_o = '0;
    if (state_q == ARB_BUSY) begin
      mem_req_o       = req_q;
      mem_req_o.valid = 1'b1;
    end
  end

  // A ready seen while IDLE belongs to nobody and is dropped here.
  always_comb begin
    icache_resp_o = '0;
    dcache_resp_o = '0;
    if ((state_q == ARB_BUSY) && mem_resp_i.ready) begin
      if (grant_q == REQ_DCACHE) begin
        dcache_resp_o       = mem_resp_i;
        dcache_resp_o.ready = 1'b1;
      end else begin
        icache_resp_o       = mem_resp_i;
        icache_resp_o.ready = 1'b1;
      end
    end
  end

endmodule
